// File: rtl/apb_pkg.sv
// Shared types and helpers for the wait-state APB completer.
package apb_pkg;

    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_state_e;

    // Error when the address is outside the array, or a write targets the read-only tail.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input logic        write,
                                      input int unsigned depth,
                                      input int unsigned ro_base);
        return (addr >= depth) || (write && (addr >= ro_base));
    endfunction

endpackage

// File: rtl/apb_ws_slave_regfile.sv
// Byte-wide register array: synchronous write, combinational read, synchronous clear.
module apb_ws_regfile
    import apb_pkg::*;
#(
    parameter int ADDR_W          = 8,
    parameter int unsigned DEPTH  = 64
) (
    input  logic                  PCLK,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [APB_DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [APB_DATA_W-1:0] mem [DEPTH];

    // Clear has priority; out-of-range writes are dropped rather than aliased.
    always_ff @(posedge PCLK) begin
        if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    // Out-of-range reads return zero instead of an arbitrary entry.
    always_comb begin
        rdata = '0;
        if (32'(raddr) < DEPTH) begin
            rdata = mem[raddr[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/apb_ws_slave.sv
// APB3 completer with a byte register file, fixed wait states and PSLVERR on bad addresses.
module apb_ws_slave
    import apb_pkg::*;
#(
    parameter int ADDR_W               = 8,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned RO_BASE     = 48,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic [APB_DATA_W-1:0] PWDATA,
    output logic [APB_DATA_W-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    apb_state_e            state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic [ADDR_W-1:0]     lat_addr, lat_addr_n;
    logic                  lat_write, lat_write_n;
    logic [APB_DATA_W-1:0] lat_wdata, lat_wdata_n;
    logic                  lat_err, lat_err_n;
    logic [APB_DATA_W-1:0] prdata_n;
    logic                  pready_n, pslverr_n;

    logic                  setup, setup_err, do_setup, we;
    logic [ADDR_W-1:0]     raddr;
    logic [APB_DATA_W-1:0] rdata, setup_rdata;

    assign setup     = PSEL && !PENABLE;
    assign setup_err = addr_err(32'(PADDR), PWRITE, DEPTH, RO_BASE);
    // During ACCESS the latched address is read; otherwise the live bus address (zero-wait reads).
    assign raddr     = (state == ACCESS) ? lat_addr : PADDR;
    // A zero-wait read setup on the same edge as a write commit must see the new value.
    assign setup_rdata = (we && (lat_addr == PADDR)) ? lat_wdata : rdata;

    apb_ws_regfile #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .PCLK   (PCLK),
        .clr    (PRESET),
        .we     (we),
        .waddr  (lat_addr),
        .wdata  (lat_wdata),
        .raddr  (raddr),
        .rdata  (rdata)
    );

    // Next-state, latch and registered-output logic.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        lat_addr_n  = lat_addr;
        lat_write_n = lat_write;
        lat_wdata_n = lat_wdata;
        lat_err_n   = lat_err;
        prdata_n    = '0;
        pready_n    = 1'b0;
        pslverr_n   = 1'b0;
        do_setup    = 1'b0;
        we          = 1'b0;

        case (state)
            IDLE: begin
                // PSEL with PENABLE but no setup phase is ignored.
                if (setup) do_setup = 1'b1;
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_n = IDLE;
                end else if (PENABLE) begin
                    cnt_n = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_n   = DONE;
                        pready_n  = 1'b1;
                        pslverr_n = lat_err;
                        prdata_n  = (!lat_write && !lat_err) ? rdata : '0;
                    end
                end
            end
            DONE: begin
                we      = lat_write && !lat_err;
                state_n = IDLE;
                if (setup) do_setup = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        if (do_setup) begin
            lat_addr_n  = PADDR;
            lat_write_n = PWRITE;
            lat_wdata_n = PWDATA;
            lat_err_n   = setup_err;
            if (WAIT_STATES == 0) begin
                state_n   = DONE;
                pready_n  = 1'b1;
                pslverr_n = setup_err;
                prdata_n  = (!PWRITE && !setup_err) ? setup_rdata : '0;
            end else begin
                state_n = ACCESS;
                cnt_n   = 4'(WAIT_STATES);
            end
        end
    end

    // Control state and bus outputs, cleared by reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            PRDATA  <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            PRDATA  <= prdata_n;
            PREADY  <= pready_n;
            PSLVERR <= pslverr_n;
        end
    end

    // Transfer attributes captured at setup; only meaningful while a transfer is in flight.
    always_ff @(posedge PCLK) begin
        lat_addr  <= lat_addr_n;
        lat_write <= lat_write_n;
        lat_wdata <= lat_wdata_n;
        lat_err   <= lat_err_n;
    end

endmodule

// File: tb/tb_apb_ws_slave.sv
// Bench for apb_ws_slave: a default-parameter instance and a zero-wait-state instance.
module tb_apb_ws_slave;

    logic       pclk;
    logic       preset;
    logic       psel_a, psel_b;
    logic       penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata_a, prdata_b;
    logic       pready_a, pready_b, pslverr_a, pslverr_b;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] rd;
        logic       err;
        int         waits;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   acc_a, acc_b;
    int   n_cmp, n_fail;

    apb_ws_slave u_dut_a (
        .PCLK(pclk), .PRESET(preset), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a)
    );

    apb_ws_slave #(.WAIT_STATES(0)) u_dut_b (
        .PCLK(pclk), .PRESET(preset), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    // Scoreboard monitor for instance A.
    always @(negedge pclk) begin
        exp_t e;
        if (psel_a && penable) begin
            if (pready_a) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_pready", 1, 0);
                end else begin
                    e = q_a.pop_front();
                    chk($sformatf("a_prdata@%0h", e.addr), prdata_a, e.rd);
                    chk($sformatf("a_pslverr@%0h", e.addr), pslverr_a, e.err);
                    chk($sformatf("a_waits@%0h", e.addr), acc_a, e.waits);
                end
                acc_a = 0;
            end else begin
                acc_a++;
            end
        end else begin
            acc_a = 0;
            if (pready_a) chk("a_stray_pready", 1, 0);
        end
    end

    // Scoreboard monitor for instance B.
    always @(negedge pclk) begin
        exp_t e;
        if (psel_b && penable) begin
            if (pready_b) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_pready", 1, 0);
                end else begin
                    e = q_b.pop_front();
                    chk($sformatf("b_prdata@%0h", e.addr), prdata_b, e.rd);
                    chk($sformatf("b_pslverr@%0h", e.addr), pslverr_b, e.err);
                    chk($sformatf("b_waits@%0h", e.addr), acc_b, e.waits);
                end
                acc_b = 0;
            end else begin
                acc_b++;
            end
        end else begin
            acc_b = 0;
            if (pready_b) chk("b_stray_pready", 1, 0);
        end
    end

    // Full transfer; called just after a rising edge and returns just after the closing edge.
    task automatic xfer(input int d, input logic wr, input logic [7:0] addr,
                        input logic [7:0] data, input logic [7:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        e.addr = addr; e.rd = exp_rd; e.err = exp_err; e.waits = (d == 0) ? 2 : 0;
        if (d == 0) q_a.push_back(e); else q_b.push_back(e);
        if (d == 0) psel_a = 1'b1; else psel_b = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge pclk); #1;
        penable = 1'b1;
        paddr = ~addr; pwdata = ~data;
        n = 0;
        forever begin
            @(negedge pclk);
            if ((d == 0) ? pready_a : pready_b) break;
            n++;
            if (n > 20) begin
                chk("pready_timeout", 1, 0);
                break;
            end
        end
        @(posedge pclk); #1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; acc_a = 0; acc_b = 0;
        preset = 1'b1; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst_prdata_a", prdata_a, 8'h00);
        chk("rst_pready_a", pready_a, 1'b0);
        chk("rst_pslverr_a", pslverr_a, 1'b0);
        chk("rst_pready_b", pready_b, 1'b0);
        @(posedge pclk); #1;
        preset = 1'b0;
        idle(1);

        // Basic write then read-back, two wait states.
        xfer(0, 1'b1, 8'h05, 8'h3C, 8'h00, 1'b0);
        xfer(0, 1'b0, 8'h05, 8'h00, 8'h3C, 1'b0);
        idle(1);

        // Address range boundaries.
        xfer(0, 1'b1, 8'h40, 8'hAA, 8'h00, 1'b1);
        xfer(0, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1);
        xfer(0, 1'b0, 8'h3F, 8'h00, 8'h00, 1'b0);
        xfer(0, 1'b1, 8'h2F, 8'h5A, 8'h00, 1'b0);
        xfer(0, 1'b0, 8'h2F, 8'h00, 8'h5A, 1'b0);

        // Read-only region rejects writes but reads normally.
        xfer(0, 1'b1, 8'h30, 8'h77, 8'h00, 1'b1);
        xfer(0, 1'b0, 8'h30, 8'h00, 8'h00, 1'b0);
        idle(2);

        // Zero wait states, back-to-back write then read.
        xfer(1, 1'b1, 8'h01, 8'h11, 8'h00, 1'b0);
        xfer(1, 1'b0, 8'h01, 8'h00, 8'h11, 1'b0);
        xfer(1, 1'b1, 8'hFF, 8'h22, 8'h00, 1'b1);
        idle(1);

        // Abort: PSEL dropped after one access cycle.
        psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h55;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel_a = 1'b0; penable = 1'b0;
        idle(3);
        xfer(0, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0);

        // Reset during a wait cycle clears outputs and memory.
        psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h55;
        @(posedge pclk); #1;
        penable = 1'b1; preset = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0; psel_a = 1'b0; penable = 1'b0;
        @(negedge pclk);
        chk("rstwait_pready", pready_a, 1'b0);
        chk("rstwait_pslverr", pslverr_a, 1'b0);
        chk("rstwait_prdata", prdata_a, 8'h00);
        @(posedge pclk); #1;
        idle(3);
        xfer(0, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0);
        xfer(0, 1'b0, 8'h05, 8'h00, 8'h00, 1'b0);
        xfer(1, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0);

        // Protocol violation: access phase with no setup.
        psel_a = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h03; pwdata = 8'h99;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            chk("violation_no_pready", pready_a, 1'b0);
        end
        @(posedge pclk); #1;
        psel_a = 1'b0; penable = 1'b0;
        idle(2);
        xfer(0, 1'b0, 8'h03, 8'h00, 8'h00, 1'b0);
        idle(3);

        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_ws_slave.md
Name: apb_ws_slave

Overview:
- APB3 completer that sits directly downstream of the apb_top master, in one of the two slave positions selected by master address bit 8.
- Holds a byte-wide register file and inserts a fixed number of wait states on every access.
- Reports PSLVERR for out-of-range addresses and for writes to the read-only region.
- Gives master-side benches a slave with real PREADY back-pressure and error responses.

Parameters:
- ADDR_W, 8: width of PADDR. This is the master's 9-bit address minus the slave-select bit.
- DEPTH, 64: number of byte locations. Valid addresses are 0..DEPTH-1. Must satisfy DEPTH <= 2**ADDR_W.
- RO_BASE, 48: addresses RO_BASE..DEPTH-1 are read-only. Setting RO_BASE = DEPTH disables the read-only region.
- WAIT_STATES, 2: number of access cycles with PREADY=0 before the completion cycle. Range 0..15.

Ports:
- PCLK, in, 1: clock. All logic is on the rising edge.
- PRESET, in, 1: synchronous, active-high reset.
- PSEL, in, 1: slave select.
- PENABLE, in, 1: access phase.
- PWRITE, in, 1: 1 = write, 0 = read.
- PADDR, in, ADDR_W: byte address.
- PWDATA, in, 8: write data.
- PRDATA, out, 8: read data. Valid only in the completion cycle.
- PREADY, out, 1: transfer completes in this cycle.
- PSLVERR, out, 1: error response. Valid only in the completion cycle.

Behaviour:
- All outputs are registered.
- Reset (PRESET=1 at a rising edge):
  - State goes to IDLE.
  - PRDATA=0x00, PREADY=0, PSLVERR=0, wait counter=0.
  - All memory locations are cleared to 0x00.
  - Any in-flight transfer is abandoned and a pending write is discarded.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - PSEL=1 and PENABLE=0 (setup phase) at an edge: latch PADDR, PWRITE, PWDATA and compute err, then go to ACCESS.
  - err = (addr >= DEPTH), or (write and addr >= RO_BASE).
  - Wait counter loads WAIT_STATES.
  - If WAIT_STATES=0, load PREADY=1 and the response outputs at the same edge, and go to DONE instead.
  - PSEL=1 with PENABLE=1 while in IDLE is a protocol violation: ignore it and stay in IDLE.
- ACCESS:
  - Each edge with PSEL=1 and PENABLE=1 decrements the counter.
  - When the counter reaches 1→0, register the outputs and go to DONE:
    - PREADY=1.
    - PSLVERR=err.
    - PRDATA = (read and !err) ? mem[addr] : 0x00.
  - PSEL=0 at an edge (master abort): go to IDLE. No write is performed and no response is given.
- DONE, which is the completion cycle (PSEL=PENABLE=PREADY=1):
  - At the closing edge, if write and !err, then mem[addr] <= latched PWDATA.
  - Outputs return to 0.
  - If PSEL=1 and PENABLE=0 at that edge (back-to-back setup), behave as IDLE setup in the same edge. Otherwise go to IDLE.
- Latency: the completion cycle is the (WAIT_STATES+1)th cycle with PENABLE high. With the default, PREADY rises 3 cycles after the setup cycle.
- Address and data are the values latched at setup. Changes to PADDR/PWDATA during ACCESS are ignored.
- A read of a location in the same transfer sequence sees the value written by the previous completed transfer, because the write commits at the DONE edge before the next setup.
- An errored transfer never modifies memory. Read-only locations read normally.
- Address boundaries:
  - addr = DEPTH-1 is valid.
  - addr = DEPTH gives an error.
  - No wrap-around.

Decomposition:
- Package apb_pkg:
  - APB state enum (IDLE/ACCESS/DONE).
  - APB_DATA_W = 8.
  - Function addr_err(addr, write, DEPTH, RO_BASE) returning the error bit.
- One natural sub-module, apb_ws_regfile: the DEPTH×8 array with synchronous write, combinational read and synchronous clear.
- The FSM and counter stay in apb_ws_slave.

Test Plan:
- Reset then a write, default params:
  - Setup addr 0x05, data 0x3C.
  - Required: PREADY low for 2 access cycles, high on the 3rd, PSLVERR=0.
  - A subsequent read of 0x05 returns PRDATA=0x3C in its completion cycle.
- Out-of-range write then read:
  - Write 0x40 (=DEPTH) with data 0xAA. Required: PSLVERR=1 in the completion cycle.
  - Read 0x40. Required: PSLVERR=1, PRDATA=0x00.
  - Read 0x3F (DEPTH-1). Required: PSLVERR=0.
- Read-only region:
  - Write 0x30 with 0x77. Required: PSLVERR=1.
  - Read 0x30. Required: returns 0x00 with PSLVERR=0.
- Back-to-back and zero wait:
  - With WAIT_STATES=0, write 0x01=0x11 then immediately read 0x01.
  - Required: PREADY=1 in the first access cycle of each transfer, and the read returns 0x11.
- Mid-transfer abort and reset:
  - Setup a write to 0x02=0x55, then drop PSEL in the 1st access cycle. Required: 0x02 still reads 0x00.
  - Repeat with PRESET=1 in the wait cycle instead. Required: PREADY/PSLVERR/PRDATA all 0 next cycle, and memory reads 0x00.
- Protocol violation:
  - PSEL=1 with PENABLE=1 and no setup phase. Required: no PREADY pulse and no memory change.
